// File: rtl/up_down_counter.sv
// ============================================================================
// Module  : up_down_counter
// Purpose : Synchronous up/down binary counter with enable, modulo 2^WIDTH,
//           and a registered one-cycle pulse on every wrap-around.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module up_down_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ctrl,
  output logic [WIDTH-1:0] counter_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_MAX  = '1;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic             w_down;
  logic [WIDTH-1:0] w_next;
  logic             w_wraps;

  assign w_down  = ctrl;
  assign w_next  = w_down ? (counter_out - C_ONE) : (counter_out + C_ONE);
  // A wrap happens when stepping past either end of the unsigned range.
  assign w_wraps = w_down ? (counter_out == C_ZERO) : (counter_out == C_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_out <= C_ZERO;
      wrap        <= 1'b0;
    end else if (en) begin
      counter_out <= w_next;
      wrap        <= w_wraps;
    end else begin
      wrap        <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_up_down_counter.sv
// ============================================================================
// Module  : tb_up_down_counter
// Purpose : Directed self-checking bench for up_down_counter (WIDTH = 5).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_down_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       ctrl;
  logic [4:0] counter_out;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  up_down_counter #(.WIDTH(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .ctrl        (ctrl),
    .counter_out (counter_out),
    .wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input logic r, input logic e, input logic c,
                      input logic [4:0] exp_cnt, input logic exp_wrap,
                      input string tag);
    reset = r;
    en    = e;
    ctrl  = c;
    @(posedge clk);
    #1;
    total++;
    assert (counter_out === exp_cnt) else begin
      bad++;
      $error("FAIL %s count: got %0d expected %0d", tag, counter_out, exp_cnt);
    end
    total++;
    assert (wrap === exp_wrap) else begin
      bad++;
      $error("FAIL %s wrap: got %0b expected %0b", tag, wrap, exp_wrap);
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    ctrl  = 1'b0;
    #2;

    // Reset, then idle with en=0
    step(1, 0, 0, 5'd0, 0, "reset");
    step(0, 0, 0, 5'd0, 0, "idle0");
    step(0, 0, 1, 5'd0, 0, "idle1");

    // Count up 0 -> 5
    step(0, 1, 0, 5'd1, 0, "up1");
    step(0, 1, 0, 5'd2, 0, "up2");
    step(0, 1, 0, 5'd3, 0, "up3");
    step(0, 1, 0, 5'd4, 0, "up4");
    step(0, 1, 0, 5'd5, 0, "up5");

    // Direction change, down through zero
    step(0, 1, 1, 5'd4,  0, "dn4");
    step(0, 1, 1, 5'd3,  0, "dn3");
    step(0, 1, 1, 5'd2,  0, "dn2");
    step(0, 1, 1, 5'd1,  0, "dn1");
    step(0, 1, 1, 5'd0,  0, "dn0");
    step(0, 1, 1, 5'd31, 1, "dnwrap31");
    step(0, 1, 1, 5'd30, 0, "dn30");
    step(0, 1, 1, 5'd29, 0, "dn29");
    step(0, 1, 1, 5'd28, 0, "dn28");
    step(0, 1, 1, 5'd27, 0, "dn27");

    // Hold with ctrl toggling
    step(0, 0, 0, 5'd27, 0, "hold_a");
    step(0, 0, 1, 5'd27, 0, "hold_b");
    step(0, 0, 0, 5'd27, 0, "hold_c");

    // Up to 31, then wrap to 0
    step(0, 1, 0, 5'd28, 0, "up28");
    step(0, 1, 0, 5'd29, 0, "up29");
    step(0, 1, 0, 5'd30, 0, "up30");
    step(0, 1, 0, 5'd31, 0, "up31");
    step(0, 1, 0, 5'd0,  1, "upwrap0");
    step(0, 1, 0, 5'd1,  0, "up1_after_wrap");

    // Count to 12
    for (int i = 2; i <= 12; i++) begin
      step(0, 1, 0, 5'(i), 0, "upto12");
    end

    // Reset priority over en, then resume
    step(1, 1, 0, 5'd0, 0, "rst_prio");
    step(0, 1, 0, 5'd1, 0, "resume1");

    // Down wrap immediately followed by hold drops the pulse
    step(0, 1, 1, 5'd0,  0, "dn_to0");
    step(0, 1, 1, 5'd31, 1, "dnwrap_again");
    step(0, 0, 0, 5'd31, 0, "hold_after_wrap");

    // Reset at max with en=1 up gives no wrap pulse
    step(1, 1, 0, 5'd0, 0, "rst_at_max");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
